// File: rtl/ps2_keyboard_tx.sv
// PS/2 device-side key event transmitter: make / F0-break scancode frames.
// Define PS2TX_EXT_EN to send an E0 prefix frame for extended keys.
module ps2_keyboard_tx #(
  parameter int CLK_DIV    = 8,
  parameter int GAP_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  input  logic       key_break,
  input  logic       key_ext,
  output logic       key_ready,
  output logic       tx_done,
  output logic       ps2_clk,
  output logic       ps2_data
);

`ifdef PS2TX_EXT_EN
  localparam bit EXT_EN = 1'b1;
`else
  localparam bit EXT_EN = 1'b0;
`endif

  localparam int HW = $clog2(CLK_DIV);
  localparam int GW = $clog2(GAP_CYCLES) + 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND_E0,
    SEND_F0,
    SEND_CODE
  } state_t;

  state_t r_state;
  state_t w_next;
  state_t w_first;

  logic [7:0]    r_code;
  logic          r_break;
  logic [3:0]    r_bit;
  logic [HW-1:0] r_half;
  logic          r_phase;
  logic          r_gap_on;
  logic [GW-1:0] r_gap;

  logic          w_accept;
  logic          w_half_end;
  logic          w_gap_end;
  logic [7:0]    w_byte;
  logic [10:0]   w_frame;

  assign w_half_end = (r_half == HALF_LAST);
  assign w_gap_end  = r_gap_on && (r_gap == GAP_LAST);
  assign w_accept   = key_valid && key_ready;

  // First byte of an event; skipped prefixes fall through immediately
  always_comb begin
    w_first = SEND_CODE;
    if (EXT_EN && key_ext)
      w_first = SEND_E0;
    else if (key_break)
      w_first = SEND_F0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (key_valid)
          w_next = w_first;
      end
      SEND_E0: begin
        if (w_gap_end)
          w_next = r_break ? SEND_F0 : SEND_CODE;
      end
      SEND_F0: begin
        if (w_gap_end)
          w_next = SEND_CODE;
      end
      SEND_CODE: begin
        if (w_gap_end)
          w_next = key_valid ? w_first : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_code  <= '0;
      r_break <= 1'b0;
    end else if (w_accept) begin
      r_code  <= key_code;
      r_break <= key_break;
    end
  end

  // Bit timing: high half, low half, then 11 bits, then the idle gap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit    <= '0;
      r_half   <= '0;
      r_phase  <= 1'b0;
      r_gap_on <= 1'b0;
      r_gap    <= '0;
    end else if (w_accept || r_state == IDLE || w_gap_end) begin
      r_bit    <= '0;
      r_half   <= '0;
      r_phase  <= 1'b0;
      r_gap_on <= 1'b0;
      r_gap    <= '0;
    end else if (r_gap_on) begin
      r_gap <= r_gap + 1'b1;
    end else if (w_half_end) begin
      r_half <= '0;
      if (!r_phase) begin
        r_phase <= 1'b1;
      end else begin
        r_phase <= 1'b0;
        if (r_bit == 4'd10)
          r_gap_on <= 1'b1;
        else
          r_bit <= r_bit + 4'd1;
      end
    end else begin
      r_half <= r_half + 1'b1;
    end
  end

  always_comb begin
    w_byte    = r_code;
    key_ready = 1'b0;
    tx_done   = 1'b0;
    ps2_clk   = 1'b1;
    ps2_data  = 1'b1;
    unique case (r_state)
      SEND_E0: w_byte = 8'hE0;
      SEND_F0: w_byte = 8'hF0;
      default: w_byte = r_code;
    endcase
    w_frame = {1'b1, ~^w_byte, w_byte, 1'b0};
    if (r_state == IDLE) begin
      key_ready = 1'b1;
    end else if (!r_gap_on) begin
      ps2_clk  = ~r_phase;
      ps2_data = w_frame[r_bit];
    end
    if (r_state == SEND_CODE && w_gap_end) begin
      tx_done   = 1'b1;
      key_ready = 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// Self-checking bench for ps2_keyboard_tx: a line monitor decodes frames and
// compares them with scancode sequences derived from each key event.
module tb_ps2_keyboard_tx;
  localparam int D  = 4;
  localparam int G  = 8;
  localparam int FR = 22 * D + G;

`ifdef PS2TX_EXT_EN
  localparam bit EXT_EN = 1'b1;
`else
  localparam bit EXT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [7:0] key_code = 8'h00;
  logic       key_break = 1'b0;
  logic       key_ext = 1'b0;
  logic       key_ready;
  logic       tx_done;
  logic       ps2_clk;
  logic       ps2_data;

  int vecs = 0;
  int errs = 0;
  int cyc = 0;

  typedef logic [7:0] bq_t[$];

  always #5 clk = ~clk;

  ps2_keyboard_tx #(
    .CLK_DIV(D),
    .GAP_CYCLES(G)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_valid(key_valid),
    .key_code(key_code),
    .key_break(key_break),
    .key_ext(key_ext),
    .key_ready(key_ready),
    .tx_done(tx_done),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data)
  );

  // Receiver model: samples data on each ps2_clk fall, one sample per cycle
  logic [10:0] frq[$];
  int          fallq[$];
  int          hiq[$];
  logic [10:0] sh = '0;
  int          nb = 0;
  int          hi_run = 0;
  logic        pc_q = 1'b1;
  logic        both_q = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      nb = 0;
      hi_run = 0;
      pc_q = 1'b1;
      both_q = 1'b1;
    end else begin
      if (pc_q && !ps2_clk) begin
        sh[nb] = ps2_data;
        nb++;
        fallq.push_back(cyc);
        if (nb == 11) begin
          frq.push_back(sh);
          nb = 0;
        end
      end
      if (both_q && ps2_clk && !ps2_data)
        hiq.push_back(hi_run);
      hi_run = (ps2_clk && ps2_data) ? hi_run + 1 : 0;
      pc_q = ps2_clk;
      both_q = ps2_clk && ps2_data;
    end
  end

  function automatic logic [10:0] frame_of(input logic [7:0] b);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++)
      ones += int'(b[i]);
    return {1'b1, (ones % 2 == 0), b, 1'b0};
  endfunction

  function automatic bq_t expect_bytes(input logic [7:0] c,
                                       input logic brk,
                                       input logic ext);
    bq_t q;
    q = {};
    if (EXT_EN && ext)
      q.push_back(8'hE0);
    if (brk)
      q.push_back(8'hF0);
    q.push_back(c);
    return q;
  endfunction

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon;
    frq.delete();
    fallq.delete();
    hiq.delete();
  endtask

  task automatic launch(input logic [7:0] c, input logic b,
                        input logic e, output int c0);
    key_code = c;
    key_break = b;
    key_ext = e;
    key_valid = 1'b1;
    c0 = cyc;
    tick;
    key_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cd,
                           output int busy_ready);
    cd = -1;
    busy_ready = 0;
    for (int i = 0; i < limit; i++) begin
      if (tx_done) begin
        cd = cyc;
        break;
      end
      if (key_ready)
        busy_ready++;
      tick;
    end
  endtask

  task automatic test_reset;
    tick;
    tick;
    vecs++;
    if ({key_ready, tx_done, ps2_clk, ps2_data} !== 4'b1011) begin
      errs++;
      $display("FAIL reset_hold: got %b want 1011",
               {key_ready, tx_done, ps2_clk, ps2_data});
    end
    rst = 1'b0;
    tick;
    tick;
    vecs++;
    if ({key_ready, tx_done, ps2_clk, ps2_data} !== 4'b1011) begin
      errs++;
      $display("FAIL reset_idle: got %b want 1011",
               {key_ready, tx_done, ps2_clk, ps2_data});
    end
  endtask

  task automatic test_press;
    int c0, cd, br;
    clear_mon();
    launch(8'h1C, 1'b0, 1'b0, c0);
    vecs++;
    if ({key_ready, ps2_clk, ps2_data} !== 3'b010) begin
      errs++;
      $display("FAIL press_start: got %b want 010",
               {key_ready, ps2_clk, ps2_data});
    end
    wait_done(400, cd, br);
    vecs++;
    if (cd - c0 !== FR) begin
      errs++;
      $display("FAIL press_done_lat: got %0d want %0d", cd - c0, FR);
    end
    vecs++;
    if (br !== 0) begin
      errs++;
      $display("FAIL press_ready_busy: got %0d want 0", br);
    end
    vecs++;
    if (frq.size() !== 1 || frq[0] !== 11'b10000111000) begin
      errs++;
      $display("FAIL press_frame: got %0d frames first %b want 10000111000",
               frq.size(), (frq.size() > 0) ? frq[0] : 11'h0);
    end
    vecs++;
    if (fallq.size() !== 11 || fallq[0] !== c0 + 1 + D ||
        fallq[10] !== c0 + 1 + 21 * D) begin
      errs++;
      $display("FAIL press_falls: got n=%0d first=%0d want n=11 first=%0d",
               fallq.size(), (fallq.size() > 0) ? fallq[0] - c0 : -1, 1 + D);
    end
    tick;
  endtask

  task automatic test_release;
    int c0, cd, br;
    clear_mon();
    launch(8'h1C, 1'b1, 1'b0, c0);
    wait_done(600, cd, br);
    vecs++;
    if (cd - c0 !== 2 * FR) begin
      errs++;
      $display("FAIL release_done_lat: got %0d want %0d", cd - c0, 2 * FR);
    end
    vecs++;
    if (frq.size() !== 2 || frq[0] !== 11'b11111100000 ||
        frq[1] !== frame_of(8'h1C)) begin
      errs++;
      $display("FAIL release_frames: got %0d frames", frq.size());
    end
    vecs++;
    if (hiq.size() !== 2 || hiq[1] !== G) begin
      errs++;
      $display("FAIL release_gap: got %0d starts gap %0d want gap %0d",
               hiq.size(), (hiq.size() > 1) ? hiq[1] : -1, G);
    end
    tick;
  endtask

  task automatic test_ignore;
    int c0, cd, br, noisy;
    clear_mon();
    launch(8'h1C, 1'b0, 1'b0, c0);
    for (int i = 0; i < 8 * D; i++)
      tick;
    key_code = 8'h32;
    key_valid = 1'b1;
    tick;
    key_valid = 1'b0;
    wait_done(400, cd, br);
    vecs++;
    if (cd - c0 !== FR) begin
      errs++;
      $display("FAIL ignore_done_lat: got %0d want %0d", cd - c0, FR);
    end
    noisy = 0;
    for (int i = 0; i < 2 * FR; i++) begin
      tick;
      if (!ps2_clk || !ps2_data || !key_ready)
        noisy++;
    end
    vecs++;
    if (noisy !== 0) begin
      errs++;
      $display("FAIL ignore_idle: got %0d busy cycles want 0", noisy);
    end
    vecs++;
    if (frq.size() !== 1 || frq[0] !== frame_of(8'h1C)) begin
      errs++;
      $display("FAIL ignore_frames: got %0d frames want 1", frq.size());
    end
  endtask

  task automatic test_async_reset;
    int c0, cd, br;
    clear_mon();
    launch(8'h1C, 1'b0, 1'b0, c0);
    for (int i = 0; i < 13 * D + 1; i++)
      tick;
    vecs++;
    if ({ps2_clk, ps2_data, key_ready} !== 3'b000) begin
      errs++;
      $display("FAIL areset_pre: got %b want 000",
               {ps2_clk, ps2_data, key_ready});
    end
    rst = 1'b1;
    #1;
    vecs++;
    if ({ps2_clk, ps2_data, key_ready, tx_done} !== 4'b1110) begin
      errs++;
      $display("FAIL areset_async: got %b want 1110",
               {ps2_clk, ps2_data, key_ready, tx_done});
    end
    tick;
    tick;
    rst = 1'b0;
    tick;
    clear_mon();
    launch(8'h15, 1'b0, 1'b0, c0);
    wait_done(400, cd, br);
    vecs++;
    if (cd - c0 !== FR) begin
      errs++;
      $display("FAIL areset_done_lat: got %0d want %0d", cd - c0, FR);
    end
    vecs++;
    if (frq.size() !== 1 || frq[0] !== 11'b10000101010) begin
      errs++;
      $display("FAIL areset_frame: got %0d frames first %b want 10000101010",
               frq.size(), (frq.size() > 0) ? frq[0] : 11'h0);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    int c0, cd, cd2, br;
    clear_mon();
    key_code = 8'h1C;
    key_break = 1'b0;
    key_ext = 1'b0;
    key_valid = 1'b1;
    c0 = cyc;
    tick;
    key_code = 8'h1B;
    vecs++;
    if (key_ready !== 1'b0) begin
      errs++;
      $display("FAIL b2b_ready_drop: got %b want 0", key_ready);
    end
    wait_done(400, cd, br);
    vecs++;
    if (cd - c0 !== FR) begin
      errs++;
      $display("FAIL b2b_first_lat: got %0d want %0d", cd - c0, FR);
    end
    tick;
    key_valid = 1'b0;
    vecs++;
    if ({key_ready, ps2_clk, ps2_data} !== 3'b010) begin
      errs++;
      $display("FAIL b2b_second_start: got %b want 010",
               {key_ready, ps2_clk, ps2_data});
    end
    wait_done(400, cd2, br);
    vecs++;
    if (cd2 - cd !== FR) begin
      errs++;
      $display("FAIL b2b_second_lat: got %0d want %0d", cd2 - cd, FR);
    end
    vecs++;
    if (hiq.size() !== 2 || hiq[1] !== G) begin
      errs++;
      $display("FAIL b2b_gap: got %0d starts gap %0d want gap %0d",
               hiq.size(), (hiq.size() > 1) ? hiq[1] : -1, G);
    end
    vecs++;
    if (frq.size() !== 2 || frq[0] !== frame_of(8'h1C) ||
        frq[1] !== frame_of(8'h1B)) begin
      errs++;
      $display("FAIL b2b_frames: got %0d frames want 2", frq.size());
    end
    tick;
  endtask

  task automatic test_ext;
    int c0, cd, br;
    bq_t exp;
    clear_mon();
    exp = expect_bytes(8'h75, 1'b1, 1'b1);
    launch(8'h75, 1'b1, 1'b1, c0);
    wait_done(800, cd, br);
    vecs++;
    if (cd - c0 !== exp.size() * FR) begin
      errs++;
      $display("FAIL ext_done_lat: got %0d want %0d", cd - c0,
               exp.size() * FR);
    end
    vecs++;
    if (frq.size() !== exp.size()) begin
      errs++;
      $display("FAIL ext_count: got %0d frames want %0d", frq.size(),
               exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        vecs++;
        if (frq[i] !== frame_of(exp[i])) begin
          errs++;
          $display("FAIL ext_frame%0d: got %b want %b", i, frq[i],
                   frame_of(exp[i]));
        end
      end
    end
    tick;
  endtask

  task automatic test_random;
    int c0, cd, br;
    logic [7:0] c;
    logic b, e;
    bq_t exp;
    for (int n = 0; n < 10; n++) begin
      clear_mon();
      c = 8'($urandom);
      b = 1'($urandom);
      e = 1'($urandom);
      exp = expect_bytes(c, b, e);
      launch(c, b, e, c0);
      wait_done(800, cd, br);
      vecs++;
      if (cd - c0 !== exp.size() * FR || br !== 0) begin
        errs++;
        $display("FAIL rand%0d_timing: got lat %0d ready %0d want %0d 0",
                 n, cd - c0, br, exp.size() * FR);
      end
      vecs++;
      if (frq.size() !== exp.size()) begin
        errs++;
        $display("FAIL rand%0d_count: got %0d want %0d", n, frq.size(),
                 exp.size());
      end else begin
        for (int i = 0; i < exp.size(); i++) begin
          vecs++;
          if (frq[i] !== frame_of(exp[i])) begin
            errs++;
            $display("FAIL rand%0d_frame%0d: got %b want %b", n, i, frq[i],
                     frame_of(exp[i]));
          end
        end
      end
      if ($urandom_range(0, 1) == 1)
        tick;
      tick;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_press();
    test_release();
    test_ignore();
    test_async_reset();
    test_back_to_back();
    test_ext();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
